// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..MaxDataBits data bits, optional parity, 1/1.5/2 stop.
// One-word holding register gives back-to-back frames; break_i forces the line low.
module uart_tx_cfg #(
  parameter int unsigned MaxDataBits  = 9,
  parameter int unsigned Oversampling = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [MaxDataBits-1:0] din_i,
  input  logic [3:0]             data_bits_i,
  input  logic [1:0]             parity_i,
  input  logic [1:0]             stop_i,
  input  logic                   break_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   eotx_o
);

  localparam int unsigned SW = $clog2(2 * Oversampling);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  localparam logic [SW-1:0] SOne       = SW'(1);
  localparam logic [SW-1:0] BitLast    = SW'(Oversampling - 1);
  localparam logic [SW-1:0] StopLast15 = SW'((3 * Oversampling) / 2 - 1);
  localparam logic [SW-1:0] StopLast2  = SW'(2 * Oversampling - 1);
  localparam logic [3:0]    MaxBits    = 4'(MaxDataBits);

  logic [2:0]             state_q, state_d;
  logic [SW-1:0]          s_q, s_d;
  logic [3:0]             n_q, n_d;
  logic [MaxDataBits-1:0] shift_q, shift_d;
  logic [3:0]             bits_q, bits_d;
  logic [1:0]             par_q, par_d;
  logic [1:0]             stop_q, stop_d;
  logic                   acc_q, acc_d;
  logic                   brk_stop_q, brk_stop_d;
  logic                   hold_vld_q, hold_vld_d;
  logic [MaxDataBits-1:0] hold_data_q, hold_data_d;
  logic [3:0]             hold_bits_q, hold_bits_d;
  logic [1:0]             hold_par_q, hold_par_d;
  logic [1:0]             hold_stop_q, hold_stop_d;
  logic                   tx_q;

  logic          xfer, par_en, bit_end, stop_end, load_hold, load_in, level;
  logic [3:0]    bits_in;
  logic [SW-1:0] stop_last;

  assign ready_o  = rst & ~hold_vld_q;
  assign xfer     = valid_i & ready_o;
  assign par_en   = (par_q == 2'b01) || (par_q == 2'b10);
  assign bit_end  = tick_i && (s_q == BitLast);
  assign stop_end = tick_i && (s_q == stop_last);
  assign busy_o   = (state_q != StIdle);
  assign eotx_o   = rst && (state_q == StStop) && stop_end && !brk_stop_q;
  assign tx_o     = tx_q;

  always_comb begin
    bits_in = data_bits_i;
    if (data_bits_i < 4'd5) begin
      bits_in = 4'd5;
    end else if (data_bits_i > MaxBits) begin
      bits_in = MaxBits;
    end
  end

  always_comb begin
    case (stop_q)
      2'b00:   stop_last = BitLast;
      2'b01:   stop_last = StopLast15;
      default: stop_last = StopLast2;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    shift_d     = shift_q;
    bits_d      = bits_q;
    par_d       = par_q;
    stop_d      = stop_q;
    acc_d       = acc_q;
    brk_stop_d  = brk_stop_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_bits_d = hold_bits_q;
    hold_par_d  = hold_par_q;
    hold_stop_d = hold_stop_q;
    load_hold   = 1'b0;
    load_in     = 1'b0;

    // Outside IDLE every accepted word parks in the holding register.
    if (xfer && (state_q != StIdle)) begin
      hold_vld_d  = 1'b1;
      hold_data_d = din_i;
      hold_bits_d = bits_in;
      hold_par_d  = parity_i;
      hold_stop_d = stop_i;
    end

    case (state_q)
      StIdle: begin
        if (hold_vld_q) begin
          load_hold = 1'b1;
        end else if (xfer) begin
          load_in = 1'b1;
        end else if (break_i) begin
          state_d = StBreak;
          stop_d  = stop_i;
          s_d     = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          s_d     = '0;
          n_d     = 4'd0;
          state_d = StData;
        end else if (tick_i) begin
          s_d = s_q + SOne;
        end
      end
      StData: begin
        if (bit_end) begin
          s_d     = '0;
          shift_d = shift_q >> 1;
          acc_d   = acc_q ^ shift_q[0];
          n_d     = n_q + 4'd1;
          if (n_q == bits_q - 4'd1) begin
            state_d = par_en ? StParity : StStop;
          end
        end else if (tick_i) begin
          s_d = s_q + SOne;
        end
      end
      StParity: begin
        if (bit_end) begin
          s_d     = '0;
          state_d = StStop;
        end else if (tick_i) begin
          s_d = s_q + SOne;
        end
      end
      StStop: begin
        if (stop_end) begin
          s_d = '0;
          if (hold_vld_q) begin
            load_hold = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (tick_i) begin
          s_d = s_q + SOne;
        end
      end
      StBreak: begin
        if (!break_i) begin
          state_d    = StStop;
          s_d        = '0;
          brk_stop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_hold || load_in) begin
      state_d    = StStart;
      s_d        = '0;
      n_d        = 4'd0;
      acc_d      = 1'b0;
      brk_stop_d = 1'b0;
      shift_d    = load_hold ? hold_data_q : din_i;
      bits_d     = load_hold ? hold_bits_q : bits_in;
      par_d      = load_hold ? hold_par_q  : parity_i;
      stop_d     = load_hold ? hold_stop_q : stop_i;
      if (load_hold) begin
        hold_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    case (state_q)
      StStart:  level = 1'b0;
      StData:   level = shift_q[0];
      StParity: level = acc_q ^ (par_q == 2'b10);
      StBreak:  level = 1'b0;
      default:  level = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      s_q         <= '0;
      n_q         <= 4'd0;
      shift_q     <= '0;
      bits_q      <= 4'd8;
      par_q       <= 2'b00;
      stop_q      <= 2'b00;
      acc_q       <= 1'b0;
      brk_stop_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_bits_q <= 4'd8;
      hold_par_q  <= 2'b00;
      hold_stop_q <= 2'b00;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      bits_q      <= bits_d;
      par_q       <= par_d;
      stop_q      <= stop_d;
      acc_q       <= acc_d;
      brk_stop_q  <= brk_stop_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_bits_q <= hold_bits_d;
      hold_par_q  <= hold_par_d;
      hold_stop_q <= hold_stop_d;
      tx_q        <= level;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: outputs recorded every falling edge and compared against
// hand-derived frame patterns (one char per bit period, 16 clk each with tick tied high).
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [8:0] din_i = '0;
  logic [3:0] data_bits_i = 4'd8;
  logic [1:0] parity_i = 2'b00;
  logic [1:0] stop_i = 2'b00;
  logic       break_i = 1'b0;
  logic       tx_o, busy_o, eotx_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic tx_buf   [0:4095];
  logic busy_buf [0:4095];
  logic eotx_buf [0:4095];
  logic rdy_buf  [0:4095];

  uart_tx_cfg #(
    .MaxDataBits (9),
    .Oversampling(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .din_i      (din_i),
    .data_bits_i(data_bits_i),
    .parity_i   (parity_i),
    .stop_i     (stop_i),
    .break_i    (break_i),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .eotx_o     (eotx_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      tx_buf[cyc]   <= tx_o;
      busy_buf[cyc] <= busy_o;
      eotx_buf[cyc] <= eotx_o;
      rdy_buf[cyc]  <= ready_o;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic smp(input int which, input int idx);
    case (which)
      0:       return tx_buf[idx];
      1:       return busy_buf[idx];
      2:       return eotx_buf[idx];
      default: return rdy_buf[idx];
    endcase
  endfunction

  function automatic int count_hi(input int which, input int from, input int len);
    int hits = 0;
    for (int i = 0; i < len; i++) if (smp(which, from + i) === 1'b1) hits++;
    return hits;
  endfunction

  // Every sample in [from, from+len) of the chosen trace must equal lvl.
  task automatic check_level(input string tag, input int which, input int from, input int len,
                             input logic lvl);
    int hi = count_hi(which, from, len);
    check_eq(tag, lvl ? hi : len - hi, len);
  endtask

  task automatic check_line(input string tag, input int base, input string pat);
    for (int k = 0; k < pat.len(); k++)
      check_level($sformatf("%s_bit%0d", tag, k), 0, base + 1 + 16 * k, 16, pat[k] == 8'h31);
  endtask

  // Exactly one eotx pulse in the frame, on the last clock of the stop period.
  task automatic check_end(input string tag, input int base, input int len);
    check_eq({tag, "_eotx_pos"},
             {29'd0, eotx_buf[base+len-2], eotx_buf[base+len-1], eotx_buf[base+len]}, 3'b010);
    check_eq({tag, "_eotx_cnt"}, count_hi(2, base, len + 1), 1);
  endtask

  task automatic check_fall(input string tag, input int idx);
    check_eq({tag, "_busy_fall"}, {30'd0, busy_buf[idx-1], busy_buf[idx]}, 2'b10);
  endtask

  task automatic goto(input int idx);
    do @(negedge clk); while (cyc < idx);
  endtask

  task automatic send_word(input logic [8:0] d, input logic [3:0] b, input logic [1:0] p,
                           input logic [1:0] s, output int base);
    int guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) check_eq("ready_timeout", {31'd0, ready_o}, 1);
    valid_i = 1'b1;
    din_i = d;
    data_bits_i = b;
    parity_i = p;
    stop_i = s;
    @(posedge clk);
    base = cyc;
    @(negedge clk);
    // Scramble inputs after the transfer: the frame must use the captured word and config.
    valid_i = 1'b0;
    din_i = 9'h1FF;
    data_bits_i = 4'd9;
    parity_i = 2'b10;
    stop_i = 2'b10;
  endtask

  initial begin
    int b, b2;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {28'd0, tx_o, busy_o, eotx_o, ready_o}, 4'b1000);
    rst = 1'b1;
    #1;
    check_eq("ready_after_reset", {31'd0, ready_o}, 1);

    // 8N1 0x0A5
    send_word(9'h0A5, 4'd8, 2'b00, 2'b00, b);
    goto(b + 162);
    #1;
    check_eq("t1_tx_latency", {31'd0, tx_buf[b]}, 1);
    check_line("t1", b, "0101001011");
    check_end("t1", b, 160);
    check_fall("t1", b + 160);

    // 8E1 0x0A5: even parity of four ones is 0
    send_word(9'h0A5, 4'd8, 2'b01, 2'b00, b);
    goto(b + 178);
    #1;
    check_line("t2e", b, "01010010101");
    check_end("t2e", b, 176);
    check_fall("t2e", b + 176);

    // 7O2 0x1C1: low 7 bits 0x41, odd parity 1, 32 clk of stop
    send_word(9'h1C1, 4'd7, 2'b10, 2'b10, b);
    goto(b + 178);
    #1;
    check_line("t2o", b, "01000001111");
    check_end("t2o", b, 176);
    check_fall("t2o", b + 176);

    // 5N1.5 0x013: 24 clk stop
    send_word(9'h013, 4'd5, 2'b00, 2'b01, b);
    goto(b + 122);
    #1;
    check_line("t3", b, "011001");
    check_level("t3_stop", 0, b + 97, 24, 1'b1);
    check_end("t3", b, 120);
    check_fall("t3", b + 120);

    // Back-to-back 0x055 then 0x0AA with no idle gap
    send_word(9'h055, 4'd8, 2'b00, 2'b00, b);
    send_word(9'h0AA, 4'd8, 2'b00, 2'b00, b2);
    goto(b + 322);
    #1;
    check_eq("t4_hold_accept", b2 - b, 2);
    check_eq("t4_ready", {29'd0, rdy_buf[b+3], rdy_buf[b+159], rdy_buf[b+160]}, 3'b001);
    check_line("t4a", b, "0101010101");
    check_line("t4b", b + 160, "0010101011");
    check_eq("t4_no_gap_busy", {31'd0, busy_buf[b+160]}, 1);
    check_end("t4a", b, 160);
    check_end("t4b", b + 160, 160);
    check_fall("t4b", b + 320);

    // Reset during data bit 3 with a word held
    send_word(9'h0A5, 4'd8, 2'b00, 2'b00, b);
    send_word(9'h00F, 4'd8, 2'b00, 2'b00, b2);
    goto(b + 70);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_in_reset", {29'd0, tx_o, busy_o, ready_o}, 3'b100);
    rst = 1'b1;
    #1;
    check_eq("t5_ready_release", {31'd0, ready_o}, 1);
    goto(b + 120);
    #1;
    check_level("t5_idle_busy", 1, b + 72, 49, 1'b0);
    check_level("t5_idle_tx", 0, b + 72, 49, 1'b1);
    check_eq("t5_no_eotx", count_hi(2, b, 121), 0);
    send_word(9'h03C, 4'd8, 2'b00, 2'b00, b);
    goto(b + 162);
    #1;
    check_line("t5", b, "0001111001");
    check_end("t5", b, 160);
    check_fall("t5", b + 160);

    // Break for 100 clk, word offered during the break goes out after the 16 clk stop
    @(negedge clk);
    break_i = 1'b1;
    stop_i = 2'b00;
    @(posedge clk);
    b = cyc;
    @(negedge clk);
    stop_i = 2'b10;
    goto(b + 49);
    send_word(9'h00F, 4'd8, 2'b00, 2'b00, b2);
    goto(b + 99);
    break_i = 1'b0;
    goto(b + 280);
    #1;
    check_level("t6_break_low", 0, b + 1, 100, 1'b0);
    check_level("t6_break_stop", 0, b + 101, 16, 1'b1);
    check_eq("t6_no_eotx", count_hi(2, b, 117), 0);
    check_level("t6_busy", 1, b, 116, 1'b1);
    check_line("t6w", b + 116, "0111100001");
    check_end("t6w", b + 116, 160);
    check_fall("t6w", b + 276);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter and successor to the fixed 8N1 transmitter. Per frame it supports 5..MaxDataBits data bits, none/even/odd parity, and 1, 1.5 or 2 stop bits. A valid/ready input with a one-word holding register gives back-to-back frames with no idle gap, and a break request drives the line low. It sits between the host/CSR side and the pad, and is paced by the shared oversampling baud tick generator.

Parameters:
MaxDataBits, 9, widest data word supported (5..9); sets din_i width
Oversampling, 16, tick_i pulses per bit period; must be even (needed for 1.5 stop)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
tick_i  input  1  oversampling tick, one clk wide
valid_i  input  1  word offered on din_i
ready_o  output  1  block can accept a word
din_i  input  MaxDataBits  data word, LSB transmitted first
data_bits_i  input  4  data bits per frame; clamped to 5..MaxDataBits
parity_i  input  2  00 none, 01 even, 10 odd, 11 none
stop_i  input  2  00 one, 01 one-and-half, 10/11 two stop bits
break_i  input  1  break request; holds line low
tx_o  output  1  serial line, registered, idle high
busy_o  output  1  a frame or break is in progress
eotx_o  output  1  one-clk pulse at the end of each frame's stop period

Behaviour:
- Reset (rst=0 at an edge): state IDLE, hold register empty, counters 0. The following outputs hold from the next edge and throughout reset:
  - tx_o=1, busy_o=0, eotx_o=0.
  - ready_o=0 while rst=0.
- Reset mid-frame aborts the frame immediately; the partial frame is discarded and the held word is dropped.
- Handshake:
  - A transfer occurs on an edge where valid_i=1 and ready_o=1.
  - ready_o=1 when not in reset and the hold register is empty.
  - din_i, data_bits_i, parity_i and stop_i are captured together at the transfer. Configuration is fixed per word; changes mid-frame have no effect.
- Word routing:
  - Transfer in IDLE: the word loads straight into the shift register, and the state becomes START on that edge.
  - Transfer in any other state: the word goes to the hold register, and ready_o drops on the next clk.
- tx_o is registered. It shows the level of the current state one clk after state entry.
- Bit timing:
  - Counter s counts tick_i.
  - START, DATA and PARITY bits each last Oversampling ticks.
  - STOP lasts Oversampling, 3*Oversampling/2 or 2*Oversampling ticks per the captured stop setting.
  - A bit ends on the tick where s equals the period minus 1; s then clears to 0.
- States:
  - IDLE: tx=1. A transfer or pending hold word leads to START. Otherwise break_i=1 leads to BREAK. Data takes priority over break.
  - START: tx=0, 1 bit, then DATA with n=0.
  - DATA: tx=shift[0]. At bit end: shift right, n+1. After n = data_bits-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = XOR of the transmitted data bits (even), or its inverse (odd). Only the data_bits LSBs are used; unused upper din bits are ignored. Then STOP.
  - STOP: tx=1. At the end of the stop period, eotx_o pulses for one clk. If the hold register is full, go to START on the same edge: the hold register moves to the shift register and ready_o rises on the next clk. This gives zero idle clocks between frames. Otherwise go to IDLE.
  - BREAK: tx=0 while break_i=1. On break_i=0, go to STOP for the full configured stop period, with the stop setting taken from stop_i at break entry; then IDLE. The break-exit STOP does not pulse eotx_o. Words may be accepted into the hold register during BREAK.
- busy_o=1 in every state except IDLE.
- tick_i=0: all counters hold and the line level holds.
- Simultaneous tick_i and a transfer in IDLE: the tick is not counted, because s starts at 0 in START.

Test Plan:
1. Setup for all cases: tick_i tied 1, Oversampling=16, MaxDataBits=9. Config 8N1, din=0x0A5, one transfer in IDLE -> tx_o low 1 clk after the transfer edge; tx_o bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 clk; eotx_o pulses at clk 160 of the frame; busy_o falls the next clk.
2. 8E1 0x0A5 -> parity bit 0, frame 176 clk. 7O2 din=0x1C1 (7 LSBs 0x41) -> data 1,0,0,0,0,0,1, parity 1, two stop bits (32 clk), frame 176 clk.
3. 5N1.5 din=0x013 -> bits 1,1,0,0,1; stop high for exactly 24 clk; then IDLE.
4. Two words 0x055 and 0x0AA offered back-to-back -> second accepted during frame 1; ready_o=0 until frame 1's stop ends; START of frame 2 immediately follows the last stop clk; two eotx_o pulses 160 clk apart.
5. rst=0 for 1 clk during DATA bit 3 with a word held -> tx_o=1, busy_o=0, ready_o=0 the next clk; held word lost. After release, ready_o=1 and a new 8N1 0x3C frame is correct.
6. break_i=1 for 100 clk from IDLE -> tx_o low 100 clk, then high 16 clk (1 stop), no eotx_o, then IDLE. A word offered during the break is sent after that stop period.
